// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, addresses the combinational instruction memory
// and hands fetched words to decode through a valid/ready IF/ID register.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] EOF_WORD = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pc_plus4,
   output logic        halted,
   output logic        fault
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HALT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t      state_q;
   logic [31:0] pc_q;
   logic        if_valid_q;
   logic [31:0] if_instr_q;
   logic [31:0] if_pc_q;
   logic [31:0] if_pc_plus4_q;
   logic        halted_q;
   logic        fault_q;

   logic        slot_free;
   logic        redirect_misaligned;
   logic [31:0] pc_inc_d;

   assign slot_free           = !if_valid_q || id_ready;
   assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
   assign pc_inc_d            = pc_q + 32'd4;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= ST_FETCH;
         pc_q          <= RESET_PC;
         if_valid_q    <= 1'b0;
         if_instr_q    <= NOP_INSTR;
         if_pc_q       <= 32'h0000_0000;
         if_pc_plus4_q <= 32'h0000_0004;
         halted_q      <= 1'b0;
         fault_q       <= 1'b0;
      end else if (redirect_valid && (state_q != ST_FAULT)) begin
         // A redirect flushes the IF/ID slot even when decode is stalled.
         if_valid_q <= 1'b0;
         if (redirect_misaligned) begin
            state_q  <= ST_FAULT;
            halted_q <= 1'b0;
            fault_q  <= 1'b1;
         end else begin
            pc_q     <= redirect_pc;
            state_q  <= ST_FETCH;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
         end
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (slot_free) begin
                  if (imem_instr == EOF_WORD) begin
                     state_q    <= ST_HALT;
                     halted_q   <= 1'b1;
                     if_valid_q <= 1'b0;
                  end else begin
                     if_instr_q    <= imem_instr;
                     if_pc_q       <= pc_q;
                     if_pc_plus4_q <= pc_inc_d;
                     if_valid_q    <= 1'b1;
                     pc_q          <= pc_inc_d;
                  end
               end
            end
            ST_HALT: begin
               if (id_ready) begin
                  if_valid_q <= 1'b0;
               end
            end
            ST_FAULT: begin
               if_valid_q <= 1'b0;
            end
            default: begin
               state_q    <= ST_FAULT;
               halted_q   <= 1'b0;
               fault_q    <= 1'b1;
               if_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign if_valid    = if_valid_q;
   assign if_instr    = if_instr_q;
   assign if_pc       = if_pc_q;
   assign if_pc_plus4 = if_pc_plus4_q;
   assign halted      = halted_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic compared
// against a cycle-level behavioural model of the fetch rules.
module tb_fetch_stage;

   localparam logic [31:0] EOF_W = 32'hDEADBEEF;
   localparam logic [31:0] NOP_W = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic        halted;
   logic        fault;

   fetch_stage #(.RESET_PC(32'h0000_0000), .EOF_WORD(EOF_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_ready       (id_ready),
      .if_valid       (if_valid),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pc_plus4    (if_pc_plus4),
      .halted         (halted),
      .fault          (fault)
   );

   always #5 clk = ~clk;

   // Instruction image: 256 words at 0..0x3FC; outside it a pattern that can never be EOF.
   logic [31:0] mem [0:255];

   function automatic logic [31:0] word_at(input logic [31:0] a);
      if (a < 32'd1024) return mem[a[9:2]];
      return {a[31:2], 2'b01};
   endfunction

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
   endtask

   // Reference model: state as plain values, 0=fetching 1=halted 2=faulted.
   int          m_st;
   logic [31:0] m_pc, m_instr, m_ipc, m_ip4;
   logic        m_v;

   task automatic model_step(input logic rn, input logic rv, input logic [31:0] rpc,
                             input logic rdy);
      logic [31:0] w;
      if (!rn) begin
         m_st = 0; m_pc = 32'h0; m_v = 1'b0; m_instr = NOP_W; m_ipc = 32'h0; m_ip4 = 32'h4;
      end else if (rv && m_st != 2) begin
         m_v = 1'b0;
         if (rpc % 4 != 0) m_st = 2;
         else begin m_pc = rpc; m_st = 0; end
      end else if (m_st == 0) begin
         if (!m_v || rdy) begin
            w = word_at(m_pc);
            if (w == EOF_W) begin m_st = 1; m_v = 1'b0; end
            else begin
               m_instr = w; m_ipc = m_pc; m_ip4 = m_pc + 32'd4; m_v = 1'b1; m_pc = m_pc + 32'd4;
            end
         end
      end else if (m_st == 1) begin
         if (rdy) m_v = 1'b0;
      end else begin
         m_v = 1'b0;
      end
   endtask

   // One clock: drive at the falling edge, compare at the next falling edge.
   task automatic cyc(input logic rn, input logic rv, input logic [31:0] rpc, input logic rdy);
      rst_n = rn; redirect_valid = rv; redirect_pc = rpc; id_ready = rdy;
      imem_instr = word_at(imem_addr);
      model_step(rn, rv, rpc, rdy);
      @(posedge clk);
      @(negedge clk);
      check("imem_addr", imem_addr, m_pc);
      check("if_valid", {31'd0, if_valid}, {31'd0, m_v});
      check("if_instr", if_instr, m_instr);
      check("if_pc", if_pc, m_ipc);
      check("if_pc_plus4", if_pc_plus4, m_ip4);
      check("halted", {31'd0, halted}, {31'd0, (m_st == 1)});
      check("fault", {31'd0, fault}, {31'd0, (m_st == 2)});
   endtask

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
      imem_instr = 32'h0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0010_0013 + (i << 7);
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0010_0113;
      m_st = 0; m_pc = 32'h0; m_v = 1'b0; m_instr = NOP_W; m_ipc = 32'h0; m_ip4 = 32'h4;
      @(negedge clk);

      // Reset values
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      check("rst_valid", {31'd0, if_valid}, 32'd0);
      check("rst_instr", if_instr, NOP_W);
      check("rst_pc4", if_pc_plus4, 32'd4);
      check("rst_addr", imem_addr, 32'd0);

      // Back-to-back fetch
      cyc(1, 0, 0, 1);
      check("t1_pc0", if_pc, 32'h0);
      check("t1_instr0", if_instr, 32'h0050_0093);
      check("t1_p4_0", if_pc_plus4, 32'h4);
      cyc(1, 0, 0, 1);
      check("t1_pc1", if_pc, 32'h4);
      check("t1_instr1", if_instr, 32'h0010_0113);
      check("t1_p4_1", if_pc_plus4, 32'h8);

      // Decode stall
      cyc(0, 0, 0, 1);
      cyc(1, 0, 0, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0);
         check("t2_hold_valid", {31'd0, if_valid}, 32'd1);
         check("t2_hold_pc", if_pc, 32'h0);
         check("t2_hold_addr", imem_addr, 32'h4);
      end
      cyc(1, 0, 0, 1);
      check("t2_resume_pc", if_pc, 32'h4);
      check("t2_resume_instr", if_instr, 32'h0010_0113);

      // Redirect while stalled
      cyc(1, 0, 0, 0);
      cyc(1, 1, 32'h40, 0);
      check("t3_flush", {31'd0, if_valid}, 32'd0);
      check("t3_addr", imem_addr, 32'h40);
      cyc(1, 0, 0, 1);
      check("t3_pc", if_pc, 32'h40);

      // End-of-image halt and restart
      mem[127] = EOF_W;
      cyc(1, 1, 32'h1F8, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("t4_halted", {31'd0, halted}, 32'd1);
      check("t4_valid", {31'd0, if_valid}, 32'd0);
      check("t4_addr", imem_addr, 32'h1FC);
      cyc(1, 0, 0, 1);
      check("t4_addr_hold", imem_addr, 32'h1FC);
      cyc(1, 1, 32'h0, 1);
      check("t4_unhalt", {31'd0, halted}, 32'd0);
      cyc(1, 0, 0, 1);
      check("t4_resume_pc", if_pc, 32'h0);

      // Misaligned redirect faults; sticky until reset
      cyc(1, 1, 32'h42, 1);
      check("t5_fault", {31'd0, fault}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 32'h0, 1);
         check("t5_sticky", {31'd0, fault}, 32'd1);
         check("t5_valid", {31'd0, if_valid}, 32'd0);
      end
      cyc(0, 0, 0, 1);
      check("t5_clear", {31'd0, fault}, 32'd0);
      check("t5_pc", imem_addr, 32'h0);

      // PC wraps at the top of the address space
      cyc(1, 1, 32'hFFFF_FFF8, 1);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      check("wrap_pc", if_pc, 32'hFFFF_FFFC);
      check("wrap_p4", if_pc_plus4, 32'h0);
      check("wrap_addr", imem_addr, 32'h0);

      // Mid-stream reset
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
      check("t6_valid", {31'd0, if_valid}, 32'd0);
      check("t6_instr", if_instr, NOP_W);
      check("t6_pc", if_pc, 32'h0);

      // Randomized traffic over a fresh image with scattered end markers
      for (int i = 0; i < 256; i++)
         mem[i] = ($urandom_range(0, 31) == 0) ? EOF_W : ($urandom() & 32'hFFFF_FFFC);
      for (int n = 0; n < 3000; n++) begin
         logic        rn, rv, rdy;
         logic [31:0] rpc;
         int          sel;
         rn  = ($urandom_range(0, 149) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 11) == 0);
         sel = $urandom_range(0, 39);
         if (sel == 0)      rpc = {$urandom_range(0, 1023)} | 32'h1;
         else if (sel == 1) rpc = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
         else               rpc = 32'($urandom_range(0, 255)) << 2;
         cyc(rn, rv, rpc, rdy);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
